fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational instruction memory in each core.
- Owns the program counter and drives the memory word address. Captures the returned instruction together with its PC into a small in-order buffer.
- Presents buffered instructions to decode via a valid/ready handshake.
- Supports fetch gating and branch/jump redirect with buffer flush.

Parameters:
- Isize, 32, instruction/address width in bits.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.
- DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- nReset  input  1  asynchronous active-low reset.
- fetch_en  input  1  permits fetching when high.
- redirect  input  1  one-cycle pulse: flush buffer and load new PC.
- redirect_pc  input  Isize  new PC when redirect=1.
- imem_addr  output  Isize  byte address to instruction memory; equals the PC register.
- imem_instr  input  Isize  instruction word returned combinationally for imem_addr in the same cycle.
- instr_valid  output  1  buffer head holds a valid instruction.
- instr  output  Isize  instruction at buffer head.
- instr_pc  output  Isize  PC of the instruction at buffer head.
- instr_ready  input  1  decode accepts the head entry this cycle.

Behaviour:
- Reset (nReset=0, asynchronous):
  - pc=RESET_PC; count, wr_ptr, rd_ptr =0; all buffer storage =0.
  - Outputs: imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- State: pc register; circular buffer of DEPTH entries {instr, pc}; wr_ptr, rd_ptr (log2 DEPTH bits, wrap naturally); count (0..DEPTH).
- Outputs:
  - imem_addr = pc, combinational from the register.
  - instr_valid = (count != 0).
  - instr and instr_pc = entry[rd_ptr], combinational from storage.
- Push condition: push = fetch_en & (count < DEPTH) & ~redirect.
  - On push: entry[wr_ptr] <= {imem_instr, pc}; wr_ptr++; pc <= pc + 4.
- Push is decided on the count at the start of the cycle. When full, no push occurs even if a pop happens the same cycle; the fetch happens on the next cycle.
- Pop condition: pop = instr_valid & instr_ready & ~redirect.
  - On pop: rd_ptr++.
  - instr/instr_pc must be held stable while instr_valid=1 and no pop occurs.
- Count update: count <= count + push - pop. Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- Redirect has highest priority:
  - pc <= {redirect_pc[Isize-1:2], 2'b00}; the low two bits are forced to zero.
  - count, wr_ptr, rd_ptr <= 0.
  - No push or pop occurs that cycle. A head entry presented that cycle is treated as not consumed; decode must discard it.
- Throughput: one instruction per cycle sustained while fetch_en=1 and decode is always ready.
- Latency:
  - Instruction at pc appears on instr with instr_valid=1 on the cycle after the clock edge that pushed it.
  - First valid output is 1 cycle after reset release, given fetch_en=1.
- pc arithmetic is modulo 2^Isize: 0xFFFFFFFC + 4 wraps to 0.
- fetch_en=0: pc holds, no push; the buffer still drains through pops.
- Empty buffer with instr_ready=1: no pop; pointers unchanged.

Test Plan:
- Reset then fetch_en=1, instr_ready=1, memory word k = 0x1000+k → instr_pc sequence 0,4,8,… with instr 0x1000,0x1001,… one per cycle; first instr_valid on cycle 1.
- instr_ready=0 for 5 cycles → buffer fills to DEPTH=2 (instr_pc 0 then 4 held), imem_addr stalls at 8. Raise instr_ready → outputs 0,4,8 in order with no loss or duplicate.
- Redirect pulse with redirect_pc=0x43 while 2 entries are buffered → next cycle instr_valid=0 and imem_addr=0x40; the following cycle instr_pc=0x40.
- Redirect and instr_ready=1 in the same cycle → count=0 afterwards; the pre-flush head is never re-presented.
- Redirect to 0xFFFFFFFC with free-running fetch → instr_pc sequence 0xFFFFFFFC, 0x0, 0x4.
- nReset asserted asynchronously mid-stream with 1 entry buffered → instr_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a combinational instruction
// memory. Owns the PC, captures {instr, pc} pairs into a small in-order
// buffer and presents the head entry to decode over a valid/ready handshake.
//
// Ports:
//   clock, nReset          - clock (rising edge), async active-low reset
//   fetch_en               - permits fetching
//   redirect, redirect_pc  - one-cycle flush + PC load (low two bits dropped)
//   imem_addr, imem_instr  - memory address (= PC) and same-cycle returned word
//   instr_valid, instr,
//   instr_pc, instr_ready  - head-of-buffer handshake towards decode
module fetch_unit #(
  parameter int unsigned     Isize    = 32,
  parameter logic [Isize-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             fetch_en,
  input  logic             redirect,
  input  logic [Isize-1:0] redirect_pc,
  output logic [Isize-1:0] imem_addr,
  input  logic [Isize-1:0] imem_instr,
  output logic             instr_valid,
  output logic [Isize-1:0] instr,
  output logic [Isize-1:0] instr_pc,
  input  logic             instr_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [Isize-1:0] pc_q, pc_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Isize-1:0] buf_instr_q [DEPTH];
  logic [Isize-1:0] buf_instr_d [DEPTH];
  logic [Isize-1:0] buf_pc_q    [DEPTH];
  logic [Isize-1:0] buf_pc_d    [DEPTH];

  logic push_c;
  logic pop_c;

  // Word alignment is forced on redirect, so the byte-offset bits are never used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Head-of-buffer and memory address views straight from the registers.
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = buf_instr_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];

  // Push uses the count at the start of the cycle: a full buffer never
  // fetches, even when decode frees a slot in the same cycle.
  assign push_c = fetch_en & (count_q < CntW'(DEPTH)) & ~redirect;
  assign pop_c  = instr_valid & instr_ready & ~redirect;

  // Next-state: redirect overrides everything, otherwise push/pop bookkeeping.
  always_comb begin
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (redirect) begin
      pc_d     = {redirect_pc[Isize-1:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        buf_instr_d[wr_ptr_q] = imem_instr;
        buf_pc_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = wr_ptr_q + PtrW'(1);
        pc_d                  = pc_q + Isize'(4);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CntW'(1);
      end else if (!push_c && pop_c) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // State registers; reset clears the whole buffer, not just the pointers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change and outputs are sampled on the
// falling clock edge; memory word k (byte address 4k) holds 0x1000 + k.
module tb_fetch_unit;

  logic        clock;
  logic        nReset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_checks;
  int n_fail;

  fetch_unit #(
    .Isize   (32),
    .RESET_PC(32'h0),
    .DEPTH   (2)
  ) dut (
    .clock      (clock),
    .nReset     (nReset),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  // Combinational instruction memory model.
  assign imem_instr = 32'h1000 + (imem_addr >> 2);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'h1);
    check({tag, "_pc"}, instr_pc, exp_pc);
    check({tag, "_instr"}, instr, 32'h1000 + (exp_pc >> 2));
  endtask

  // Hold reset for two cycles and check the reset-state outputs.
  task automatic apply_reset();
    nReset = 1'b0;
    step();
    step();
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    nReset      = 1'b0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    @(negedge clock);

    // Streaming: one instruction per cycle, first valid one cycle after release.
    apply_reset();
    nReset      = 1'b1;
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    check("pre_edge_valid", 32'(instr_valid), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_head("stream", 32'(4 * k));
      check("stream_addr", imem_addr, 32'(4 * k + 4));
    end

    // Backpressure: fills to two entries, head held, PC stalls at 8.
    apply_reset();
    nReset      = 1'b1;
    fetch_en    = 1'b1;
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_head("stall", 32'h0);
    end
    check("stall_addr", imem_addr, 32'h8);
    instr_ready = 1'b1;
    step();
    check_head("drain1", 32'h4);
    check("drain1_addr", imem_addr, 32'h8);
    step();
    check_head("drain2", 32'h8);
    check("drain2_addr", imem_addr, 32'hC);

    // Redirect with two buffered entries; low address bits dropped.
    instr_ready = 1'b0;
    step();
    step();
    check_head("prefill", 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    step();
    check("redir_valid", 32'(instr_valid), 32'h0);
    check("redir_addr", imem_addr, 32'h40);
    redirect    = 1'b0;
    instr_ready = 1'b1;
    step();
    check_head("redir_head", 32'h40);

    // Redirect coinciding with instr_ready: old head is never re-presented.
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    check("flush_valid", 32'(instr_valid), 32'h0);
    check("flush_addr", imem_addr, 32'h100);
    redirect = 1'b0;
    fetch_en = 1'b0;
    step();
    check("flush_hold_valid", 32'(instr_valid), 32'h0);
    check("flush_hold_addr", imem_addr, 32'h100);
    fetch_en = 1'b1;
    step();
    check_head("flush_head", 32'h100);

    // PC wraps modulo 2^32.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    check_head("wrap0", 32'hFFFF_FFFC);
    step();
    check_head("wrap1", 32'h0);
    step();
    check_head("wrap2", 32'h4);

    // fetch_en=0: PC holds while the buffer drains; empty + ready pops nothing.
    instr_ready = 1'b0;
    step();
    check_head("fill2", 32'h4);
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    step();
    check_head("gate_drain", 32'h8);
    check("gate_addr", imem_addr, 32'hC);
    step();
    check("gate_empty", 32'(instr_valid), 32'h0);
    step();
    check("empty_ready_valid", 32'(instr_valid), 32'h0);
    check("empty_ready_addr", imem_addr, 32'hC);
    fetch_en = 1'b1;
    step();
    check_head("resume", 32'hC);

    // Asynchronous reset mid-stream with one entry buffered.
    check("pre_async_valid", 32'(instr_valid), 32'h1);
    #2 nReset = 1'b0;
    #1;
    check("async_valid", 32'(instr_valid), 32'h0);
    check("async_addr", imem_addr, 32'h0);
    check("async_instr", instr, 32'h0);
    check("async_pc", instr_pc, 32'h0);
    step();
    nReset = 1'b1;
    step();
    check_head("post_async", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
